gray_step_monitor: RTL
======================

// Module: gray_step_monitor
// PURPOSE
//   Downstream consumer of the Gray counter output. Samples the Gray code each
//   cycle, decodes it to binary, and checks every sample against the expected
//   sequence: hold when the counter was not enabled, +1 mod SIZE when it was.
//   Reports lock status, step errors, wrap events and a saturating error count
//   for debug/status registers.
// PARAMETERS
//   SIZE        16  counter modulus; must match the upstream counter (>=2)
//   LOCK_CYCLES 4   consecutive good samples required to assert locked (>=1)
//   ERR_W       8   width of err_count
//   Derived: W = $clog2(SIZE), the code width
// PORTS
//   clk        in   1      rising-edge clock, shared with the Gray counter
//   reset      in   1      synchronous active-high reset
//   step_en    in   1      the counter's enable, tapped at the same cycle
//   gray_in    in   W      Gray code from the counter
//   bin_out    out  W      registered binary decode of gray_in
//   bin_valid  out  1      bin_out holds a decoded sample
//   locked     out  1      sequence verified for LOCK_CYCLES samples
//   step_err   out  1      one-cycle pulse on a sequence mismatch
//   wrap       out  1      one-cycle pulse on an accepted SIZE-1 -> 0 step
//   err_count  out  ERR_W  saturating count of step_err pulses
// BEHAVIOUR
// - Reset (sync): all outputs 0, state=ACQ, ref=0, good_cnt=0, en_q=0.
// - Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Combinational into registers.
// - Registered outputs: a sample taken at edge n appears on the outputs after
//   edge n (1-cycle latency).
// - en_q <= step_en every cycle. The counter updates on the edge that samples
//   its en, so the sample at edge n is checked against en_q (step_en at n-1).
// - Expected value: exp = en_q ? (ref==SIZE-1 ? 0 : ref+1) : ref.
// - Mismatch: decoded != exp, or decoded >= SIZE (code outside the range).
// - Wrap from SIZE-1 to 0 is legal for any SIZE, including non-power-of-2 SIZE
//   where the wrap changes more than one bit. Checks use value only, never
//   Hamming distance.
// - FSM states: ACQ, VERIFY, LOCKED.
//   ACQ: first sample after reset. ref<=decoded; good_cnt<=0; bin_valid<=1;
//     go to VERIFY. No check and no step_err. An out-of-range first sample
//     stays in ACQ with bin_valid=0.
//   VERIFY: match -> ref<=decoded, good_cnt++. When good_cnt reaches
//     LOCK_CYCLES -> LOCKED, and locked=1 on the same edge.
//     Mismatch -> step_err, ref<=decoded (resync), good_cnt<=0, stay in VERIFY.
//     An out-of-range sample also sends the FSM to ACQ.
//   LOCKED: match -> ref<=decoded.
//     Mismatch -> step_err, locked<=0, ref resync, good_cnt<=0, go to VERIFY
//     (ACQ if out of range).
// - wrap: pulses in VERIFY or LOCKED on a match with en_q=1 and ref==SIZE-1.
// - err_count: +1 per step_err pulse; saturates at 2^ERR_W-1 and never wraps.
// - step_err and wrap are never set together.
// - step_en has no effect on the current cycle's check; it only updates en_q.
// - Reset mid-operation overrides everything in that cycle. The next sample
//   re-enters ACQ and err_count clears.
// TESTING
// 1 SIZE=16, LOCK_CYCLES=4; reset, then real counter with en=1 continuously ->
//   locked=1 on the 5th output cycle; wrap pulses once per 16 cycles at
//   gray 4'b1000->4'b0000; err_count=0.
// 2 SIZE=10; run through the wrap (bin 9, gray 4'b1101 -> 4'b0000) ->
//   no step_err, wrap=1 for one cycle, locked stays 1.
// 3 Locked, en=1; force gray 4'b0011 (bin 2) -> 4'b0110 (bin 4) ->
//   step_err 1 cycle, locked=0, err_count=1; relocks 4 good cycles later.
// 4 Locked, en=0 (hold) but gray changes 4'b0001->4'b0011 -> step_err.
//   Then en toggling 1,0,1,0 with a true counter -> no errors.
// 5 SIZE=10; drive gray 4'b1111 (bin 10) -> step_err, FSM to ACQ,
//   bin_valid=0; next legal sample restores bin_valid=1.
// 6 ERR_W=2; inject 5 errors -> err_count=3 (saturated). Assert reset
//   mid-run -> next cycle all outputs 0, err_count=0.

Source files
------------

// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: decodes the upstream counter's Gray output and checks
// each sample for hold/+1 behaviour, reporting lock, step errors and wraps.
module gray_step_monitor #(
  parameter int SIZE        = 16,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W       = 8,
  localparam int W          = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic [W-1:0]     gray_in,
  output logic [W-1:0]     bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [W-1:0]     LAST_VAL  = W'(SIZE - 1);
  localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t          state_r;
  logic [W-1:0]    ref_r;
  logic [GW-1:0]   good_cnt_r;
  logic            en_q_r;

  logic [W-1:0]    decoded_s;
  logic            in_range_s;
  logic            at_last_s;
  logic [W-1:0]    exp_s;
  logic            match_s;
  logic [ERR_W-1:0] err_next_s;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Decode, range check and expected-value comparison for the current sample.
  always_comb begin
    decoded_s  = gray_to_bin(gray_in);
    in_range_s = (32'(decoded_s) < 32'(SIZE));
    at_last_s  = (ref_r == LAST_VAL);
    exp_s      = ref_r;
    if (en_q_r) begin
      if (at_last_s) begin
        exp_s = {W{1'b0}};
      end else begin
        exp_s = ref_r + W'(1);
      end
    end else begin
      exp_s = ref_r;
    end
    match_s = in_range_s && (decoded_s == exp_s);
    if (err_count != ERR_MAX) begin
      err_next_s = err_count + ERR_W'(1);
    end else begin
      err_next_s = err_count;
    end
  end

  // Sequence-tracking FSM with all status outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_ACQ;
      ref_r      <= {W{1'b0}};
      good_cnt_r <= {GW{1'b0}};
      en_q_r     <= 1'b0;
      bin_out    <= {W{1'b0}};
      bin_valid  <= 1'b0;
      locked     <= 1'b0;
      step_err   <= 1'b0;
      wrap       <= 1'b0;
      err_count  <= {ERR_W{1'b0}};
    end else begin
      en_q_r    <= step_en;
      bin_out   <= decoded_s;
      bin_valid <= in_range_s;
      case (state_r)
        ST_ACQ: begin
          step_err   <= 1'b0;
          wrap       <= 1'b0;
          locked     <= 1'b0;
          good_cnt_r <= {GW{1'b0}};
          if (in_range_s) begin
            ref_r   <= decoded_s;
            state_r <= ST_VERIFY;
          end else begin
            state_r <= ST_ACQ;
          end
        end
        ST_VERIFY, ST_LOCKED: begin
          ref_r <= decoded_s;
          if (match_s) begin
            step_err <= 1'b0;
            wrap     <= en_q_r && at_last_s;
            if (state_r == ST_LOCKED) begin
              locked  <= 1'b1;
              state_r <= ST_LOCKED;
            end else if (good_cnt_r == LOCK_LAST) begin
              good_cnt_r <= {GW{1'b0}};
              locked     <= 1'b1;
              state_r    <= ST_LOCKED;
            end else begin
              good_cnt_r <= good_cnt_r + GW'(1);
              locked     <= 1'b0;
              state_r    <= ST_VERIFY;
            end
          end else begin
            // Resync to the observed value; a code outside the range forces reacquisition.
            step_err   <= 1'b1;
            wrap       <= 1'b0;
            locked     <= 1'b0;
            good_cnt_r <= {GW{1'b0}};
            err_count  <= err_next_s;
            if (in_range_s) begin
              state_r <= ST_VERIFY;
            end else begin
              state_r <= ST_ACQ;
            end
          end
        end
        default: begin
          state_r    <= ST_ACQ;
          good_cnt_r <= {GW{1'b0}};
          step_err   <= 1'b0;
          wrap       <= 1'b0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

endmodule
